// File: rtl/pwm_dac.sv
// Registered PWM DAC: truncates a 16-bit level to CNT_BITS of duty, updated only at period boundaries.
// Define PWM_DITHER_EN to add first-order error-feedback dither of the discarded low bits.
`timescale 1ns/1ps

module pwm_dac #(
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [15:0]         sample_in,
    output logic                pwm_out,
    output logic                sample_take,
    output logic [CNT_BITS-1:0] duty_q
);

    localparam int LOW_BITS = 16 - CNT_BITS;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_PRE = CNT_BITS'((2 ** CNT_BITS) - 2);

    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] sample_hi;
    logic [CNT_BITS-1:0] new_duty;
    logic                load_duty;

    assign sample_hi = sample_in[15:LOW_BITS];
    assign load_duty = !enable || (cnt == CNT_MAX);

`ifdef PWM_DITHER_EN
    logic [LOW_BITS-1:0] err;
    logic [LOW_BITS:0]   dither_sum;

    // The carry out of the residue accumulator bumps the duty by one LSB, saturating at full scale.
    always_comb begin
        dither_sum = {1'b0, sample_in[LOW_BITS-1:0]} + {1'b0, err};
        new_duty   = sample_hi;
        if (dither_sum[LOW_BITS] && (sample_hi != CNT_MAX)) begin
            new_duty = sample_hi + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= '0;
        end else if (load_duty) begin
            err <= dither_sum[LOW_BITS-1:0];
        end
    end
`else
    logic unused_low_bits;

    assign unused_low_bits = ^sample_in[LOW_BITS-1:0];
    assign new_duty        = sample_hi;
`endif

    // sample_take is registered one cycle early so it is high exactly while cnt sits at its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            duty_q      <= '0;
            pwm_out     <= 1'b0;
            sample_take <= 1'b0;
        end else if (!enable) begin
            cnt         <= '0;
            duty_q      <= new_duty;
            pwm_out     <= 1'b0;
            sample_take <= 1'b0;
        end else begin
            cnt         <= cnt + 1'b1;
            pwm_out     <= (cnt < duty_q);
            sample_take <= (cnt == CNT_PRE);
            if (cnt == CNT_MAX) begin
                duty_q <= new_duty;
            end
        end
    end

endmodule

// File: tb/tb_pwm_dac.sv
// Directed self-checking bench for pwm_dac at CNT_BITS=8: a vector table for reset/idle/start
// behaviour plus whole-period sequences for duty, update timing, enable drop and dither.
`timescale 1ns/1ps

module tb_pwm_dac;

    localparam int CNT_BITS = 8;
    localparam int PERIOD   = 256;

`ifdef PWM_DITHER_EN
    localparam int EXP_TOTAL_HIGH = 32896;
    localparam int EXP_ODD_DUTY   = 128;
    localparam int EXP_TOGGLES    = 255;
`else
    localparam int EXP_TOTAL_HIGH = 32768;
    localparam int EXP_ODD_DUTY   = 0;
    localparam int EXP_TOGGLES    = 0;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                enable = 1'b0;
    logic [15:0]         sample_in = 16'h0000;
    logic                pwm_out;
    logic                sample_take;
    logic [CNT_BITS-1:0] duty_q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        reset;
        logic        enable;
        logic [15:0] sample;
        logic        exp_pwm;
        logic        exp_take;
        logic [7:0]  exp_duty;
    } vec_t;

    vec_t vecs[11];

    pwm_dac #(.CNT_BITS(CNT_BITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sample_in   (sample_in),
        .pwm_out     (pwm_out),
        .sample_take (sample_take),
        .duty_q      (duty_q)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic applyStimulus(input logic r, input logic e, input logic [15:0] s);
        reset     = r;
        enable    = e;
        sample_in = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic startRun(input logic [15:0] s);
        applyStimulus(1'b1, 1'b0, s);
        applyStimulus(1'b0, 1'b0, s);
        enable = 1'b1;
    endtask

    task automatic measurePeriod(input int change_at, input logic [15:0] new_sample,
                                 output int highs, output int rises, output int takes,
                                 output logic [7:0] duty_seen);
        logic prev;
        prev      = pwm_out;
        highs     = 0;
        rises     = 0;
        takes     = 0;
        duty_seen = duty_q;
        for (int k = 0; k < PERIOD; k++) begin
            if (k == change_at) sample_in = new_sample;
            @(posedge clk);
            @(negedge clk);
            if (pwm_out) highs++;
            if (pwm_out && !prev) rises++;
            if (sample_take) takes++;
            prev = pwm_out;
        end
    endtask

    initial begin
        int         highs;
        int         rises;
        int         takes;
        int         total;
        int         odd;
        int         toggles;
        logic [7:0] duty_seen;
        logic [7:0] prev_duty;

        vecs[0]  = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 8'h80};
        vecs[5]  = '{1'b0, 1'b0, 16'h4000, 1'b0, 1'b0, 8'h40};
        vecs[6]  = '{1'b0, 1'b1, 16'h4000, 1'b1, 1'b0, 8'h40};
        vecs[7]  = '{1'b0, 1'b1, 16'hC000, 1'b1, 1'b0, 8'h40};
        vecs[8]  = '{1'b1, 1'b1, 16'hC000, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 8'hFF};
        vecs[10] = '{1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 8'hFF};

        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].reset, vecs[i].enable, vecs[i].sample);
            checkOutput($sformatf("vec%0d pwm_out", i), 32'(pwm_out), 32'(vecs[i].exp_pwm));
            checkOutput($sformatf("vec%0d sample_take", i), 32'(sample_take), 32'(vecs[i].exp_take));
            checkOutput($sformatf("vec%0d duty_q", i), 32'(duty_q), 32'(vecs[i].exp_duty));
        end

        // Half scale: one 128-clock burst and one sample_take per period.
        startRun(16'h8000);
        for (int p = 0; p < 2; p++) begin
            measurePeriod(-1, 16'h8000, highs, rises, takes, duty_seen);
            checkOutput($sformatf("half p%0d highs", p), highs, 128);
            checkOutput($sformatf("half p%0d rises", p), rises, 1);
            checkOutput($sformatf("half p%0d takes", p), takes, 1);
            checkOutput($sformatf("half p%0d duty", p), duty_seen, 8'h80);
        end

        // Zero scale, then full scale arriving at the start of a period.
        startRun(16'h0000);
        measurePeriod(-1, 16'h0000, highs, rises, takes, duty_seen);
        checkOutput("zero highs", highs, 0);
        checkOutput("zero takes", takes, 1);
        measurePeriod(0, 16'hFFFF, highs, rises, takes, duty_seen);
        checkOutput("zero->full old highs", highs, 0);
        checkOutput("zero->full old duty", duty_seen, 8'h00);
        measurePeriod(-1, 16'hFFFF, highs, rises, takes, duty_seen);
        checkOutput("full highs", highs, 255);
        checkOutput("full rises", rises, 1);
        checkOutput("full duty", duty_seen, 8'hFF);
        checkOutput("full duty_q now", duty_q, 8'hFF);

        // Mid-period change must wait for the boundary.
        startRun(16'h4000);
        measurePeriod(10, 16'hC000, highs, rises, takes, duty_seen);
        checkOutput("midchange cur highs", highs, 64);
        checkOutput("midchange cur duty", duty_seen, 8'h40);
        measurePeriod(-1, 16'hC000, highs, rises, takes, duty_seen);
        checkOutput("midchange next highs", highs, 192);
        checkOutput("midchange next duty", duty_seen, 8'hC0);

        // Enable dropped at cnt=40, then a fresh period from cnt=0.
        startRun(16'h8000);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("drop pre pwm", pwm_out, 1);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("drop pwm", pwm_out, 0);
        checkOutput("drop take", sample_take, 0);
        checkOutput("drop duty", duty_q, 8'h80);
        enable = 1'b1;
        measurePeriod(-1, 16'h8000, highs, rises, takes, duty_seen);
        checkOutput("reenable highs", highs, 128);
        checkOutput("reenable rises", rises, 1);
        checkOutput("reenable takes", takes, 1);

        // Long-run average of 0x8080 exposes the dither.
        startRun(16'h8080);
        total     = 0;
        odd       = 0;
        toggles   = 0;
        prev_duty = 8'h00;
        for (int p = 0; p < 256; p++) begin
            measurePeriod(-1, 16'h8080, highs, rises, takes, duty_seen);
            total += highs;
            if (duty_seen == 8'h81) odd++;
            if (p > 0 && duty_seen != prev_duty) toggles++;
            prev_duty = duty_seen;
        end
        checkOutput("dither total highs", total, EXP_TOTAL_HIGH);
        checkOutput("dither odd periods", odd, EXP_ODD_DUTY);
        checkOutput("dither toggles", toggles, EXP_TOGGLES);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_dac.md
PWM_DAC -- requirements
Module: pwm_dac

Interface
REQ-001 Parameter CNT_BITS, default 8, meaning PWM resolution in bits; legal range 4..12; period is 2^CNT_BITS clocks.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  run PWM when high; idle when low.
REQ-005 sample_in  input  16  unsigned level from upstream waveform generator, held between updates.
REQ-006 pwm_out  output  1  registered PWM output.
REQ-007 sample_take  output  1  one-cycle pulse marking the cycle in which sample_in is latched while running.
REQ-008 duty_q  output  CNT_BITS  duty value in force for the current period.

Function
REQ-009 Internal period counter cnt, CNT_BITS wide, SHALL increment by 1 each clock while enable=1 and wrap from 2^CNT_BITS-1 to 0.
REQ-010 While enable=0: cnt SHALL be forced to 0, pwm_out to 0, sample_take to 0, and duty_q SHALL load the new duty (REQ-012) every clock.
REQ-011 While enable=1 and cnt=2^CNT_BITS-1 (last cycle of period): duty_q SHALL load the new duty and sample_take SHALL be 1 in that same cycle; otherwise duty_q holds.
REQ-012 New duty without dither = sample_in[15:16-CNT_BITS] (truncation).
REQ-013 pwm_out SHALL be registered as (enable AND cnt < duty_q), using pre-edge values: one-clock latency from cnt/duty_q to pin.
REQ-014 duty_q=0 -> pwm_out never high; duty_q=2^CNT_BITS-1 -> high 2^CNT_BITS-1 of 2^CNT_BITS clocks; 100% duty is not reachable.
REQ-015 sample_in changes mid-period SHALL NOT affect the current period; glitch-free update at period boundary only.
REQ-016 enable rising: first period starts at cnt=0 using the duty loaded during the last enable=0 cycle; enable falling mid-period: pwm_out=0 on the next clock, period abandoned.
REQ-017 No combinational path from any input to any output.

Reset
REQ-018 reset=1 SHALL set cnt=0, duty_q=0, pwm_out=0, sample_take=0, and dither error accumulator=0 on the next rising edge; reset overrides enable.
REQ-019 Reset asserted mid-period SHALL abandon the period; after release, behaviour per REQ-010/REQ-016.

Configuration
REQ-020 Macro PWM_DITHER_EN SHALL select first-order error-feedback dither of the discarded low bits.
REQ-021 With PWM_DITHER_EN: at every duty load, sum = sample_in[15-CNT_BITS:0] + err (16-CNT_BITS bits plus carry); new duty = sample_in[15:16-CNT_BITS] + carry, saturating at 2^CNT_BITS-1; err <= sum low 16-CNT_BITS bits (carry dropped on saturation, err still updated).
REQ-022 Without PWM_DITHER_EN: no err register; duty per REQ-012; all other behaviour identical.

Verification (CNT_BITS=8)
REQ-023 Assert reset 3 clocks with enable=1, sample_in=0xFFFF -> pwm_out=0, duty_q=0, sample_take=0 throughout and 1 clock after release.
REQ-024 enable=1, sample_in=0x8000 -> per 256-clock period pwm_out high exactly 128 consecutive clocks, sample_take pulses once per 256 clocks.
REQ-025 sample_in=0x0000 -> pwm_out always 0; sample_in=0xFFFF -> pwm_out high 255 of 256 clocks, duty_q=0xFF.
REQ-026 sample_in 0x4000 -> 0xC000 at cnt=10 -> current period high 64 clocks, next period high 192 clocks.
REQ-027 enable dropped at cnt=40 with duty_q=0x80 -> pwm_out=0 next clock, cnt=0; re-enable -> full 128-clock high phase from cnt=0.
REQ-028 sample_in=0x8080 for 256 periods -> total high clocks 32896 with PWM_DITHER_EN, 32768 without; duty_q alternates 0x80/0x81 with dither.
